// File: rtl/div_seq32.sv
// Sequential signed divider: radix-2 restoring division on operand magnitudes,
// one quotient bit per cycle, sign fix-up in a final cycle, one-cycle done pulse.
module div_seq32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
    logic [WIDTH:0]   rem_sh, trial;

    always_comb begin
        a_mag  = a[WIDTH-1] ? -a : a;
        b_mag  = b[WIDTH-1] ? -b : b;
        rem_sh = {rem[WIDTH-1:0], dvd[WIDTH-1]};
        trial  = rem_sh - {1'b0, dsr};
        q_fix  = sign_q ? -dvd : dvd;
        r_fix  = sign_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvd    <= a_mag;
                        dsr    <= b_mag;
                        sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r <= a[WIDTH-1];
                        dz     <= (b == '0);
                        cnt    <= CW'(WIDTH - 1);
                        busy   <= 1'b1;
                        // On divide-by-zero, |a| parked in rem makes the FIX sign
                        // restore reproduce the original dividend as the remainder.
                        if (b == '0) begin
                            rem   <= {1'b0, a_mag};
                            state <= FIX;
                        end else begin
                            rem   <= '0;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem <= trial;
                        dvd <= {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem <= rem_sh;
                        dvd <= {dvd[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) state <= FIX;
                end
                FIX: begin
                    quotient    <= dz ? '1 : q_fix;
                    remainder   <= r_fix;
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
